// File: rtl/rob_commit.sv
// Reorder buffer: allocates slots at issue, collects ALU/LSB results and retires in program order.
// A mispredicted branch retires normally, then flushes the whole buffer one cycle later.
module rob_commit #(
    parameter int ROB_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdy,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_dest,
    input  logic                  issue_is_branch,
    input  logic                  issue_is_jalr,
    input  logic                  issue_pred_jump,
    input  logic [31:0]           issue_alt_pc,
    output logic [ROB_ADDR_W-1:0] issue_rename,
    output logic                  rob_full,
    input  logic                  wb_alu_valid,
    input  logic [ROB_ADDR_W-1:0] wb_alu_rename,
    input  logic [31:0]           wb_alu_value,
    input  logic                  wb_lsb_valid,
    input  logic [ROB_ADDR_W-1:0] wb_lsb_rename,
    input  logic [31:0]           wb_lsb_value,
    output logic                  commit_flag,
    output logic [31:0]           commit_value,
    output logic [ROB_ADDR_W-1:0] commit_rename,
    output logic [4:0]            commit_dest,
    output logic                  commit_is_branch,
    output logic                  commit_is_jalr,
    output logic                  rob_flush,
    output logic [31:0]           flush_pc
);
    localparam int DEPTH = 1 << ROB_ADDR_W;
    localparam logic [ROB_ADDR_W:0] FULL_CNT = (ROB_ADDR_W + 1)'(DEPTH);

    logic [ROB_ADDR_W-1:0] head_q, head_d;
    logic [ROB_ADDR_W-1:0] tail_q, tail_d;
    logic [ROB_ADDR_W:0]   count_q, count_d;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] ready_q;
    logic [DEPTH-1:0] is_branch_q;
    logic [DEPTH-1:0] is_jalr_q;
    logic [DEPTH-1:0] pred_q;
    logic [31:0]      value_q  [DEPTH];
    logic [31:0]      alt_pc_q [DEPTH];
    logic [4:0]       dest_q   [DEPTH];

    logic                  flush_pending_q;
    logic                  rob_flush_q;
    logic [31:0]           flush_pc_q;
    logic                  commit_flag_q;
    logic [31:0]           commit_value_q;
    logic [ROB_ADDR_W-1:0] commit_rename_q;
    logic [4:0]            commit_dest_q;
    logic                  commit_is_branch_q;
    logic                  commit_is_jalr_q;

    logic blocked;
    logic do_commit;
    logic do_issue;
    logic alu_wr;
    logic lsb_wr;
    logic mispredict;

    // The retire cycle of a mispredict and the flush cycle after it accept nothing.
    assign blocked    = flush_pending_q | rob_flush_q;
    assign rob_full   = (count_q == FULL_CNT);
    assign do_commit  = rdy & ~blocked & busy_q[head_q] & ready_q[head_q];
    assign do_issue   = rdy & ~blocked & issue_valid & ~rob_full;
    assign alu_wr     = rdy & ~blocked & wb_alu_valid & busy_q[wb_alu_rename];
    assign lsb_wr     = rdy & ~blocked & wb_lsb_valid & busy_q[wb_lsb_rename];
    assign mispredict = is_branch_q[head_q] & (value_q[head_q][0] != pred_q[head_q]);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (rdy && flush_pending_q) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_commit) head_d = head_q + 1'b1;
            if (do_issue)  tail_d = tail_q + 1'b1;
            case ({do_issue, do_commit})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q             <= '0;
            tail_q             <= '0;
            count_q            <= '0;
            busy_q             <= '0;
            ready_q            <= '0;
            flush_pending_q    <= 1'b0;
            rob_flush_q        <= 1'b0;
            flush_pc_q         <= '0;
            commit_flag_q      <= 1'b0;
            commit_value_q     <= '0;
            commit_rename_q    <= '0;
            commit_dest_q      <= '0;
            commit_is_branch_q <= 1'b0;
            commit_is_jalr_q   <= 1'b0;
        end else if (rdy) begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            commit_flag_q <= do_commit;
            rob_flush_q   <= flush_pending_q;
            if (flush_pending_q) begin
                busy_q          <= '0;
                ready_q         <= '0;
                flush_pending_q <= 1'b0;
            end else begin
                if (do_commit) begin
                    busy_q[head_q]     <= 1'b0;
                    ready_q[head_q]    <= 1'b0;
                    commit_value_q     <= value_q[head_q];
                    commit_rename_q    <= head_q;
                    commit_dest_q      <= dest_q[head_q];
                    commit_is_branch_q <= is_branch_q[head_q];
                    commit_is_jalr_q   <= is_jalr_q[head_q];
                    if (mispredict) begin
                        flush_pending_q <= 1'b1;
                        flush_pc_q      <= alt_pc_q[head_q];
                    end
                end
                if (alu_wr) ready_q[wb_alu_rename] <= 1'b1;
                if (lsb_wr) ready_q[wb_lsb_rename] <= 1'b1;
                if (do_issue) begin
                    busy_q[tail_q]  <= 1'b1;
                    ready_q[tail_q] <= 1'b0;
                end
            end
        end else begin
            commit_flag_q <= 1'b0;
            rob_flush_q   <= 1'b0;
        end
    end

    // Payload needs no reset: busy/ready gate every use of it.
    always_ff @(posedge clk) begin
        if (do_issue) begin
            dest_q[tail_q]      <= issue_dest;
            is_branch_q[tail_q] <= issue_is_branch;
            is_jalr_q[tail_q]   <= issue_is_jalr;
            pred_q[tail_q]      <= issue_pred_jump;
            alt_pc_q[tail_q]    <= issue_alt_pc;
        end
        if (alu_wr) value_q[wb_alu_rename] <= wb_alu_value;
        if (lsb_wr) value_q[wb_lsb_rename] <= wb_lsb_value;
    end

    assign issue_rename     = tail_q;
    assign commit_flag      = commit_flag_q;
    assign commit_value     = commit_value_q;
    assign commit_rename    = commit_rename_q;
    assign commit_dest      = commit_dest_q;
    assign commit_is_branch = commit_is_branch_q;
    assign commit_is_jalr   = commit_is_jalr_q;
    assign rob_flush        = rob_flush_q;
    assign flush_pc         = flush_pc_q;

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: directed scenarios then random traffic, scored against
// a queue model of the buffer; a negedge monitor pops and compares expected retirements.
`timescale 1ns/1ps
module tb_rob_commit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        issue_is_branch;
    logic        issue_is_jalr;
    logic        issue_pred_jump;
    logic [31:0] issue_alt_pc;
    logic [3:0]  issue_rename;
    logic        rob_full;
    logic        wb_alu_valid;
    logic [3:0]  wb_alu_rename;
    logic [31:0] wb_alu_value;
    logic        wb_lsb_valid;
    logic [3:0]  wb_lsb_rename;
    logic [31:0] wb_lsb_value;
    logic        commit_flag;
    logic [31:0] commit_value;
    logic [3:0]  commit_rename;
    logic [4:0]  commit_dest;
    logic        commit_is_branch;
    logic        commit_is_jalr;
    logic        rob_flush;
    logic [31:0] flush_pc;

    rob_commit #(.ROB_ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy),
        .issue_valid(issue_valid), .issue_dest(issue_dest),
        .issue_is_branch(issue_is_branch), .issue_is_jalr(issue_is_jalr),
        .issue_pred_jump(issue_pred_jump), .issue_alt_pc(issue_alt_pc),
        .issue_rename(issue_rename), .rob_full(rob_full),
        .wb_alu_valid(wb_alu_valid), .wb_alu_rename(wb_alu_rename), .wb_alu_value(wb_alu_value),
        .wb_lsb_valid(wb_lsb_valid), .wb_lsb_rename(wb_lsb_rename), .wb_lsb_value(wb_lsb_value),
        .commit_flag(commit_flag), .commit_value(commit_value), .commit_rename(commit_rename),
        .commit_dest(commit_dest), .commit_is_branch(commit_is_branch),
        .commit_is_jalr(commit_is_jalr), .rob_flush(rob_flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  dest;
        logic        br;
        logic        jalr;
        logic        pred;
        logic        done;
        logic [31:0] alt;
        logic [31:0] val;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [31:0] val;
        logic [3:0]  tag;
        logic [4:0]  dest;
        logic        br;
        logic        jalr;
    } cexp_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
    } fexp_t;

    ent_t        m_rob[$];
    cexp_t       exp_c[$];
    fexp_t       exp_f[$];
    logic [3:0]  m_tail  = 4'd0;
    int          m_stage = 0;   // 0 normal, 1 flush owed, 2 flush cycle
    logic [31:0] m_fpc   = 32'd0;
    int          m_cyc   = 0;
    bit          m_full;
    ent_t        m_e;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, m_cyc);
    endtask

    // Reference model: one step per rising edge, from the inputs the bench applied.
    always @(posedge clk) begin
        if (rst_n) begin
            m_cyc++;
            if (m_stage == 2) begin
                m_stage = 0;
            end else if (rdy) begin
                if (m_stage == 1) begin
                    exp_f.push_back('{m_cyc, m_fpc});
                    m_rob.delete();
                    m_tail  = 4'd0;
                    m_stage = 2;
                end else begin
                    m_full = (m_rob.size() == 16);
                    if (m_rob.size() > 0 && m_rob[0].done) begin
                        m_e = m_rob.pop_front();
                        exp_c.push_back('{m_cyc, m_e.val, m_e.tag, m_e.dest, m_e.br, m_e.jalr});
                        if (m_e.br && (m_e.val[0] != m_e.pred)) begin
                            m_stage = 1;
                            m_fpc   = m_e.alt;
                        end
                    end
                    foreach (m_rob[i]) begin
                        if (wb_alu_valid && m_rob[i].tag == wb_alu_rename) begin
                            m_rob[i].done = 1'b1;
                            m_rob[i].val  = wb_alu_value;
                        end
                        if (wb_lsb_valid && m_rob[i].tag == wb_lsb_rename) begin
                            m_rob[i].done = 1'b1;
                            m_rob[i].val  = wb_lsb_value;
                        end
                    end
                    if (issue_valid && !m_full) begin
                        m_rob.push_back('{m_tail, issue_dest, issue_is_branch, issue_is_jalr,
                                          issue_pred_jump, 1'b0, issue_alt_pc, 32'd0});
                        m_tail = m_tail + 4'd1;
                    end
                end
            end
        end
    end

    bit    mon_ec, mon_ef;
    cexp_t ce;
    fexp_t fe;

    always @(negedge clk) begin
        if (rst_n) begin
            mon_ec = (exp_c.size() > 0) && (exp_c[0].cyc == m_cyc);
            chk("commit_flag", 32'(commit_flag), 32'(mon_ec));
            if (mon_ec) begin
                ce = exp_c.pop_front();
                if (commit_flag) begin
                    chk("commit_value", commit_value, ce.val);
                    chk("commit_rename", 32'(commit_rename), 32'(ce.tag));
                    chk("commit_dest", 32'(commit_dest), 32'(ce.dest));
                    chk("commit_is_branch", 32'(commit_is_branch), 32'(ce.br));
                    chk("commit_is_jalr", 32'(commit_is_jalr), 32'(ce.jalr));
                end
            end
            mon_ef = (exp_f.size() > 0) && (exp_f[0].cyc == m_cyc);
            chk("rob_flush", 32'(rob_flush), 32'(mon_ef));
            if (mon_ef) begin
                fe = exp_f.pop_front();
                if (rob_flush) chk("flush_pc", flush_pc, fe.pc);
            end
            chk("issue_rename", 32'(issue_rename), 32'(m_tail));
            chk("rob_full", 32'(rob_full), 32'(m_rob.size() == 16));
        end
    end

    task automatic idle();
        issue_valid  = 1'b0;
        wb_alu_valid = 1'b0;
        wb_lsb_valid = 1'b0;
    endtask

    task automatic clear_model();
        m_rob.delete();
        exp_c.delete();
        exp_f.delete();
        m_tail  = 4'd0;
        m_stage = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rdy   = 1'b1;
        rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_issue(input logic [4:0] dest, input logic br, input logic jalr,
                              input logic pred, input logic [31:0] alt, output logic [3:0] tag);
        @(negedge clk);
        idle();
        rdy             = 1'b1;
        issue_valid     = 1'b1;
        issue_dest      = dest;
        issue_is_branch = br;
        issue_is_jalr   = jalr;
        issue_pred_jump = pred;
        issue_alt_pc    = alt;
        tag             = m_tail;
    endtask

    task automatic send_wb(input bit lsb, input logic [3:0] tag, input logic [31:0] val);
        @(negedge clk);
        idle();
        rdy = 1'b1;
        if (lsb) begin
            wb_lsb_valid = 1'b1; wb_lsb_rename = tag; wb_lsb_value = val;
        end else begin
            wb_alu_valid = 1'b1; wb_alu_rename = tag; wb_alu_value = val;
        end
    endtask

    function automatic bit tag_live(input logic [3:0] t);
        foreach (m_rob[i]) if (m_rob[i].tag == t) return 1'b1;
        return 1'b0;
    endfunction

    task automatic pick_wb(input bit en_alu, input bit en_lsb, input bit stray);
        int         cand[$];
        int         k;
        logic [3:0] t;
        foreach (m_rob[i]) if (!m_rob[i].done) cand.push_back(i);
        if (en_alu && cand.size() > 0) begin
            k = int'($urandom_range(0, cand.size() - 1));
            wb_alu_valid  = 1'b1;
            wb_alu_rename = m_rob[cand[k]].tag;
            wb_alu_value  = $urandom;
            cand.delete(k);
        end
        if (en_lsb && cand.size() > 0) begin
            k = int'($urandom_range(0, cand.size() - 1));
            wb_lsb_valid  = 1'b1;
            wb_lsb_rename = m_rob[cand[k]].tag;
            wb_lsb_value  = $urandom;
        end else if (stray) begin
            t = 4'($urandom);
            if (!tag_live(t)) begin
                wb_lsb_valid  = 1'b1;
                wb_lsb_rename = t;
                wb_lsb_value  = $urandom;
            end
        end
    endtask

    task automatic drain(input int budget);
        bit done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge clk);
            idle();
            rdy = 1'b1;
            if (m_rob.size() == 0 && m_stage == 0 && exp_c.size() == 0 && exp_f.size() == 0)
                done = 1'b1;
            else
                pick_wb(1'b1, 1'b1, 1'b0);
        end
        chk("drain_complete", 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1, "watchdog");
    end

    logic [3:0] t, t2;
    bit         seen;
    int         r;

    initial begin
        rst_n = 1'b0; rdy = 1'b1;
        idle();
        issue_dest = '0; issue_is_branch = 1'b0; issue_is_jalr = 1'b0;
        issue_pred_jump = 1'b0; issue_alt_pc = '0;
        wb_alu_rename = '0; wb_alu_value = '0; wb_lsb_rename = '0; wb_lsb_value = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        @(negedge clk);
        chk("t1_commit_flag", 32'(commit_flag), 32'd0);
        chk("t1_rob_full", 32'(rob_full), 32'd0);
        chk("t1_issue_rename", 32'(issue_rename), 32'd0);
        chk("t1_rob_flush", 32'(rob_flush), 32'd0);

        // Out-of-order writeback, in-order retirement
        send_issue(5'd1, 1'b0, 1'b0, 1'b0, 32'd0, t);
        send_issue(5'd2, 1'b0, 1'b0, 1'b0, 32'd0, t);
        send_issue(5'd3, 1'b0, 1'b0, 1'b0, 32'd0, t);
        send_wb(1'b0, 4'd2, 32'h33);
        send_wb(1'b1, 4'd0, 32'h11);
        send_wb(1'b0, 4'd1, 32'h22);
        repeat (5) begin @(negedge clk); idle(); end

        // Fill, reject when full, commit+issue, tail wrap
        do_reset();
        for (int i = 0; i < 16; i++) send_issue(5'(i + 1), 1'b0, 1'b0, 1'b0, 32'd0, t);
        send_issue(5'd20, 1'b0, 1'b0, 1'b0, 32'd0, t);
        @(negedge clk);
        idle();
        chk("t3_full", 32'(rob_full), 32'd1);
        chk("t3_tail_stays", 32'(issue_rename), 32'd0);
        wb_alu_valid = 1'b1; wb_alu_rename = 4'd0; wb_alu_value = 32'hA0;
        wb_lsb_valid = 1'b1; wb_lsb_rename = 4'd1; wb_lsb_value = 32'hA1;
        @(negedge clk);
        idle(); issue_valid = 1'b1; issue_dest = 5'd21;
        @(negedge clk);
        idle(); issue_valid = 1'b1; issue_dest = 5'd21;
        @(negedge clk);
        idle();
        chk("t3_wrap_tail", 32'(issue_rename), 32'd1);
        drain(200);

        // Mispredicted branch -> flush, redirect, tag restarts at 0
        send_issue(5'd0, 1'b1, 1'b0, 1'b0, 32'h80, t);
        send_wb(1'b0, t, 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            idle();
            if (rob_flush) seen = 1'b1;
        end
        chk("t4_flush_seen", 32'(seen), 32'd1);
        chk("t4_flush_pc", flush_pc, 32'h80);
        chk("t4_tag_after_flush", 32'(issue_rename), 32'd0);
        send_issue(5'd7, 1'b0, 1'b0, 1'b0, 32'd0, t);
        drain(50);

        // Correct branch prediction and jalr: no flush
        send_issue(5'd0, 1'b1, 1'b0, 1'b1, 32'h200, t);
        send_issue(5'd1, 1'b0, 1'b1, 1'b0, 32'h0, t2);
        send_wb(1'b0, t, 32'd1);
        send_wb(1'b0, t2, 32'h1000);
        repeat (4) begin @(negedge clk); idle(); end
        drain(50);

        // rdy=0 holds a ready head for three edges
        send_issue(5'd9, 1'b0, 1'b0, 1'b0, 32'd0, t);
        send_wb(1'b1, t, 32'h66);
        repeat (3) begin
            @(negedge clk);
            idle(); rdy = 1'b0;
            chk("t6_no_commit_frozen", 32'(commit_flag), 32'd0);
        end
        @(negedge clk);
        chk("t6_no_commit_frozen", 32'(commit_flag), 32'd0);
        rdy = 1'b1;
        @(negedge clk);
        chk("t6_commit_after_rdy", 32'(commit_flag), 32'd1);

        // Flush owed across rdy=0
        send_issue(5'd4, 1'b1, 1'b0, 1'b1, 32'h300, t);
        send_wb(1'b0, t, 32'd0);
        @(negedge clk); idle(); rdy = 1'b1;
        @(negedge clk); rdy = 1'b0;
        @(negedge clk); rdy = 1'b0;
        @(negedge clk); rdy = 1'b1;
        repeat (3) begin @(negedge clk); idle(); end
        drain(50);

        // Async reset while full
        for (int i = 0; i < 16; i++) send_issue(5'(i), 1'b0, 1'b0, 1'b0, 32'd0, t);
        @(negedge clk);
        idle();
        chk("t6_full_before_reset", 32'(rob_full), 32'd1);
        #2;
        rst_n = 1'b0;
        clear_model();
        #1;
        chk("t6_reset_full", 32'(rob_full), 32'd0);
        chk("t6_reset_tail", 32'(issue_rename), 32'd0);
        chk("t6_reset_commit", 32'(commit_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            idle();
            rdy = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 2) != 0) begin
                r = int'($urandom_range(0, 3));
                issue_valid     = 1'b1;
                issue_dest      = 5'($urandom);
                issue_is_branch = (r == 0);
                issue_is_jalr   = (r == 1);
                issue_pred_jump = 1'($urandom);
                issue_alt_pc    = $urandom & 32'hFFFF_FFFC;
            end
            pick_wb(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
        end
        drain(300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
